// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential instruction step; wraps at 2^64.
  function automatic logic [ADDR_W-1:0] pc_step(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered storage, push/pop every cycle, flush wins over push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  input  logic                   flush,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Entry storage; data is never reset, only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy tracking; flush empties the queue in one cycle.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the fetch PC, issues credit-limited requests to a
// variable-latency instruction memory, buffers responses and applies redirects.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [63:0] RESET_PC = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic [63:0] if_link
);

  localparam int            CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CRED_MAX = (CW+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]     outstanding_q, outstanding_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full;
  logic              credit_ok, req_raw, granted;
  logic              push, pop, flush;
  fetch_entry_t      push_entry, head_entry;

  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};
  assign pop        = if_valid && if_ready;
  assign imem_addr  = fetch_pc_q;

  // Zero the head fields when nothing is buffered so decode never sees stale data.
  assign if_valid = !fifo_empty;
  assign if_pc    = if_valid ? head_entry.pc    : '0;
  assign if_instr = if_valid ? head_entry.instr : '0;
  assign if_link  = pc_step(if_pc);

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Next-state: credit check, grant/response bookkeeping, then redirect override.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    push          = 1'b0;
    flush         = 1'b0;
    req_raw       = 1'b0;
    credit_ok     = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CRED_MAX;

    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     req_raw = credit_ok;
      FLUSH:   req_raw = 1'b0;
      default: state_d = IDLE;
    endcase

    // A redirect abandons the request on the bus, but a grant the memory
    // gives in that same cycle is still an in-flight word to be discarded.
    imem_req = req_raw && !redirect;
    granted  = req_raw && imem_gnt;

    if (granted) begin
      outstanding_d = outstanding_d + CW'(1);
      fetch_pc_d    = pc_step(fetch_pc_q);
    end

    if (imem_rvalid && (outstanding_q != '0)) begin
      outstanding_d = outstanding_d - CW'(1);
      if (discard_q == '0) begin
        push      = 1'b1;
        resp_pc_d = pc_step(resp_pc_q);
      end else begin
        discard_d = discard_q - CW'(1);
      end
    end

    if ((state_q == FLUSH) && (discard_d == '0)) begin
      state_d = RUN;
    end

    if (redirect && (state_q != IDLE)) begin
      flush      = 1'b1;
      discard_d  = outstanding_d;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      state_d    = (outstanding_d != '0) ? FLUSH : RUN;
    end
  end

  // Control and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // A response with nothing outstanding is a memory protocol violation.
  a_no_orphan_rvalid: assert property (
    @(posedge clk) disable iff (!reset) imem_rvalid |-> (outstanding_q != '0));

  // The credit rule must keep the prefetch FIFO from overflowing.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!reset) !(push && fifo_full && !pop && !flush));

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: behavioural instruction memory, scoreboard of
// granted addresses, a cycle table for startup/backpressure/reset, and
// hand-written stall and redirect sequences.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset, redirect, imem_req, imem_gnt, imem_rvalid;
  logic        if_valid, if_ready;
  logic [63:0] redirect_pc, imem_addr, if_pc, if_link;
  logic [31:0] imem_rdata, if_instr;

  fetch_controller #(.DEPTH(4), .RESET_PC(64'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_ready    (if_ready),
    .if_link     (if_link)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { int due; logic [63:0] addr; } pend_t;
  typedef struct {
    logic rst; logic rdy; logic chk;
    logic exp_req; logic [63:0] exp_addr; logic exp_vld; logic [63:0] exp_pc;
  } vec_t;

  exp_t  sb [$];
  pend_t pend [$];
  vec_t  vt [24];

  int          cyc = 0, lat = 1, n_cmp = 0, n_bad = 0, rvalid_cnt = 0;
  int          n_drop, rv0;
  logic        gnt_en = 1'b1;
  logic        cur_rst, cur_redir;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_pc;
  logic [31:0] prev_instr;
  logic        got_pop, seen_200, found, got;
  logic [63:0] first_pop_pc, a0;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(input logic r, input logic rd, input logic c,
                              input logic q, input int a, input logic v, input int p);
    vec_t t;
    t.rst = r; t.rdy = rd; t.chk = c;
    t.exp_req = q; t.exp_addr = 64'(a); t.exp_vld = v; t.exp_pc = 64'(p);
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle's inputs (memory model included) and let outputs settle.
  task automatic cyc_begin(input logic rst, input logic rdy, input logic redir,
                           input logic [63:0] rpc);
    pend_t p;
    cur_rst = rst; cur_redir = redir;
    reset = rst; if_ready = rdy; redirect = redir; redirect_pc = rpc;
    imem_gnt = gnt_en && !redir && rst;
    imem_rvalid = 1'b0; imem_rdata = '0;
    if (!rst) pend.delete();
    else if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(p.addr);
      rvalid_cnt++;
    end
    #1;
    if (cyc > 1) chk("link", if_link, if_pc + 64'd4);
    if (prev_hold) begin
      chk("hold_pc", if_pc, prev_pc);
      chk("hold_instr", {32'd0, if_instr}, {32'd0, prev_instr});
    end
  endtask

  // Record the handshakes of this cycle, then advance past the clock edge.
  task automatic cyc_end();
    exp_t e;
    if (cur_rst && if_valid && if_pc[63:8] == 56'h2) seen_200 = 1'b1;
    if (cur_rst && if_valid && if_ready) begin
      if (!got_pop) begin got_pop = 1'b1; first_pop_pc = if_pc; end
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_unexpected cyc=%0d got_pc=%h want=none", cyc, if_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", if_pc, e.pc);
        chk("sb_instr", {32'd0, if_instr}, {32'd0, e.instr});
      end
    end
    if (!cur_rst || cur_redir) sb.delete();
    if (cur_rst && imem_req && imem_gnt) begin
      pend.push_back('{cyc + lat, imem_addr});
      sb.push_back('{imem_addr, instr_of(imem_addr)});
    end
    prev_hold  = cur_rst && !cur_redir && if_valid && !if_ready;
    prev_pc    = if_pc;
    prev_instr = if_instr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin(1'b1, 1'b1, 1'b0, '0);
      cyc_end();
    end
  endtask

  task automatic wait_outstanding3();
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (pend.size() >= 3) got = 1'b1;
      else begin cyc_begin(1'b1, 1'b1, 1'b0, '0); cyc_end(); end
    end
    chk1("reach_outstanding", got, 1'b1);
  endtask

  task automatic wait_first_req(input string name, input logic [63:0] want);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc_begin(1'b1, 1'b1, 1'b0, '0);
      if (imem_req) begin
        found = 1'b1;
        chk(name, imem_addr, want);
        chk({name, "_dropped"}, 64'(rvalid_cnt - rv0), 64'(n_drop));
      end
      cyc_end();
    end
    chk1({name, "_flush_exit"}, found, 1'b1);
  endtask

  task automatic wait_first_pop(input string name, input logic [63:0] want);
    for (int i = 0; i < 30 && !got_pop; i++) begin
      cyc_begin(1'b1, 1'b1, 1'b0, '0);
      cyc_end();
    end
    chk1({name, "_seen"}, got_pop, 1'b1);
    chk(name, first_pop_pc, want);
  endtask

  initial begin
    got_pop = 1'b1; seen_200 = 1'b0; first_pop_pc = '0;
    //        rst rdy chk req addr vld pc
    vt[0]  = mk(0, 1, 0, 0,  0, 0,  0);
    vt[1]  = mk(0, 1, 1, 0,  0, 0,  0);
    vt[2]  = mk(1, 1, 1, 0,  0, 0,  0);
    vt[3]  = mk(1, 1, 1, 1,  0, 0,  0);
    vt[4]  = mk(1, 1, 1, 1,  4, 0,  0);
    vt[5]  = mk(1, 1, 1, 1,  8, 1,  0);
    vt[6]  = mk(1, 1, 1, 1, 12, 1,  4);
    vt[7]  = mk(1, 1, 1, 1, 16, 1,  8);
    vt[8]  = mk(1, 1, 1, 1, 20, 1, 12);
    vt[9]  = mk(1, 0, 1, 1, 24, 1, 16);
    vt[10] = mk(0, 0, 1, 1, 28, 1, 16);
    vt[11] = mk(1, 0, 1, 0,  0, 0,  0);
    vt[12] = mk(1, 0, 1, 1,  0, 0,  0);
    vt[13] = mk(1, 0, 1, 1,  4, 0,  0);
    vt[14] = mk(1, 0, 1, 1,  8, 1,  0);
    vt[15] = mk(1, 0, 1, 1, 12, 1,  0);
    vt[16] = mk(1, 0, 1, 0, 16, 1,  0);
    vt[17] = mk(1, 0, 1, 0, 16, 1,  0);
    vt[18] = mk(1, 0, 1, 0, 16, 1,  0);
    vt[19] = mk(1, 1, 1, 0, 16, 1,  0);
    vt[20] = mk(1, 1, 1, 1, 16, 1,  4);
    vt[21] = mk(1, 1, 1, 1, 20, 1,  8);
    vt[22] = mk(1, 1, 1, 1, 24, 1, 12);
    vt[23] = mk(1, 1, 1, 1, 28, 1, 16);

    // Startup, backpressure to a full FIFO, mid-stream reset, release.
    for (int i = 0; i < 24; i++) begin
      cyc_begin(vt[i].rst, vt[i].rdy, 1'b0, '0);
      if (vt[i].chk) begin
        chk1("tbl_req", imem_req, vt[i].exp_req);
        chk("tbl_addr", imem_addr, vt[i].exp_addr);
        chk1("tbl_valid", if_valid, vt[i].exp_vld);
        chk("tbl_pc", if_pc, vt[i].exp_pc);
        if (!vt[i].rst && i == 1) begin
          chk("rst_instr", {32'd0, if_instr}, 64'd0);
          chk("rst_link", if_link, 64'd4);
        end
      end
      cyc_end();
    end

    // Grant withheld for three cycles: request and address must hold.
    gnt_en = 1'b0;
    cyc_begin(1'b1, 1'b1, 1'b0, '0);
    a0 = imem_addr;
    chk1("stall_req", imem_req, 1'b1);
    cyc_end();
    for (int i = 0; i < 2; i++) begin
      cyc_begin(1'b1, 1'b1, 1'b0, '0);
      chk1("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, a0);
      cyc_end();
    end
    gnt_en = 1'b1;
    cyc_begin(1'b1, 1'b1, 1'b0, '0);
    chk("stall_release_addr", imem_addr, a0);
    cyc_end();
    cyc_begin(1'b1, 1'b1, 1'b0, '0);
    chk("stall_next_addr", imem_addr, a0 + 64'd4);
    cyc_end();
    run(6);

    // Redirect with several requests in flight at latency 4.
    lat = 4;
    wait_outstanding3();
    cyc_begin(1'b1, 1'b1, 1'b1, 64'h100);
    chk1("b_req_on_redirect", imem_req, 1'b0);
    n_drop = pend.size();
    cyc_end();
    rv0 = rvalid_cnt; got_pop = 1'b0;
    cyc_begin(1'b1, 1'b1, 1'b0, '0);
    chk1("b_valid_after_redirect", if_valid, 1'b0);
    chk1("b_req_in_flush", imem_req, 1'b0);
    cyc_end();
    wait_first_req("b_first_addr", 64'h100);
    wait_first_pop("b_first_pc", 64'h100);
    run(8);

    // Redirect, then redirect again while still flushing.
    wait_outstanding3();
    cyc_begin(1'b1, 1'b1, 1'b1, 64'h200);
    cyc_end();
    seen_200 = 1'b0; got_pop = 1'b0;
    cyc_begin(1'b1, 1'b1, 1'b1, 64'h300);
    chk1("c_valid_after_redirect", if_valid, 1'b0);
    n_drop = pend.size();
    cyc_end();
    rv0 = rvalid_cnt;
    wait_first_req("c_first_addr", 64'h300);
    wait_first_pop("c_first_pc", 64'h300);
    run(12);
    chk1("c_no_0x200_entry", seen_200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
